// File: rtl/trig_angle_entry.sv
//==============================================================================
// Module   : trig_angle_entry
// Brief    : Two-button angle entry (up/down) producing an 8-bit phase angle,
//            with synchronisers, per-key debounce and optional auto-repeat.
// Options  : define TRIG_ANGLE_REPEAT_EN to build the hold-to-auto-repeat path.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module trig_angle_entry #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_PERIOD   = 5000000,
    parameter logic [7:0] RESET_ANGLE     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic [7:0] angle_out,
    output logic       angle_step,
    output logic       repeat_active
);

    localparam int c_dbWidth = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_dbWidth-1:0] c_dbMax = c_dbWidth'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Bit 0 is the up key, bit 1 the down key.
    logic [1:0] w_keyRaw;
    logic [1:0] w_debPressed;
    logic [1:0] r_debPrev;
    logic [1:0] w_press;

    assign w_keyRaw = {key_dn_n, key_up_n};

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic                 r_sync1;
        logic                 r_sync2;
        logic                 r_deb;
        logic [c_dbWidth-1:0] r_dbCnt;

        // The debounced level only follows the synchronised level after it
        // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b0;
                r_dbCnt <= '0;
            end else begin
                r_sync1 <= w_keyRaw[i];
                r_sync2 <= r_sync1;
                if (~r_sync2 == r_deb) begin
                    r_dbCnt <= '0;
                end else if (r_dbCnt == c_dbMax) begin
                    r_deb   <= ~r_sync2;
                    r_dbCnt <= '0;
                end else begin
                    r_dbCnt <= r_dbCnt + 1'b1;
                end
            end
        end

        assign w_debPressed[i] = r_deb;
    end

    assign w_press = w_debPressed & ~r_debPrev;

    state_t     r_state;
    state_t     w_stateNext;
    logic       r_dir;          // 0 = up, 1 = down
    logic       w_dirNext;
    logic       w_step;
    logic       w_stepDn;
    logic       w_timerRst;
    logic       w_heldPressed;
    logic       w_otherPressed;
    logic [7:0] r_angle;
    logic       r_step;

    assign w_heldPressed  = r_dir ? w_debPressed[1] : w_debPressed[0];
    assign w_otherPressed = r_dir ? w_debPressed[0] : w_debPressed[1];

`ifdef TRIG_ANGLE_REPEAT_EN
    localparam int c_tmMax   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_tmWidth = $clog2(c_tmMax + 1);
    localparam logic [c_tmWidth-1:0] c_delayLast  = c_tmWidth'(REPEAT_DELAY - 1);
    localparam logic [c_tmWidth-1:0] c_periodLast = c_tmWidth'(REPEAT_PERIOD - 1);

    logic [c_tmWidth-1:0] r_timer;

    // Timer counts cycles since the most recent step while a key is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_timerRst || (w_stateNext != S_HOLD && w_stateNext != S_REPEAT)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign repeat_active = (r_state == S_REPEAT);
`else
    logic w_unusedRepeatCfg;
    assign w_unusedRepeatCfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign repeat_active     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_debPrev <= 2'b00;
            r_angle   <= RESET_ANGLE;
            r_step    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_dir     <= w_dirNext;
            r_debPrev <= w_debPressed;
            r_step    <= w_step;
            if (w_step) begin
                r_angle <= w_stepDn ? (r_angle - 8'd1) : (r_angle + 8'd1);
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_dirNext   = r_dir;
        w_step      = 1'b0;
        w_stepDn    = r_dir;
        w_timerRst  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press != 2'b00) begin
                    if (&w_debPressed) begin
                        w_stateNext = S_LOCK;
                    end else begin
                        w_step      = 1'b1;
                        w_stepDn    = w_press[1];
                        w_dirNext   = w_press[1];
                        w_timerRst  = 1'b1;
                        w_stateNext = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!w_heldPressed) begin
                    w_stateNext = S_IDLE;
                end else if (w_otherPressed) begin
                    w_stateNext = S_LOCK;
                end
`ifdef TRIG_ANGLE_REPEAT_EN
                else if (r_timer == c_delayLast) begin
                    w_step      = 1'b1;
                    w_timerRst  = 1'b1;
                    w_stateNext = S_REPEAT;
                end
`endif
            end
`ifdef TRIG_ANGLE_REPEAT_EN
            S_REPEAT: begin
                // Release is checked first so a step due on the same cycle is dropped.
                if (!w_heldPressed) begin
                    w_stateNext = S_IDLE;
                end else if (w_otherPressed) begin
                    w_stateNext = S_LOCK;
                end else if (r_timer == c_periodLast) begin
                    w_step     = 1'b1;
                    w_timerRst = 1'b1;
                end
            end
`endif
            S_LOCK: begin
                if (w_debPressed == 2'b00) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign angle_out  = r_angle;
    assign angle_step = r_step;

endmodule

`default_nettype wire

// File: tb/tb_trig_angle_entry.sv
//==============================================================================
// Module   : tb_trig_angle_entry
// Brief    : Directed bench for trig_angle_entry (DEBOUNCE_CYCLES=4,
//            REPEAT_DELAY=20, REPEAT_PERIOD=5); follows TRIG_ANGLE_REPEAT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_trig_angle_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic [7:0] angle_out;
    logic       angle_step;
    logic       repeat_active;

    int         total = 0;
    int         bad = 0;
    int         stepCnt = 0;
    int         t = 0;
    int         baseCnt;
    logic [7:0] expAngle;

    trig_angle_entry #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5),
        .RESET_ANGLE    (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_up_n     (key_up_n),
        .key_dn_n     (key_dn_n),
        .angle_out    (angle_out),
        .angle_step   (angle_step),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && angle_step) stepCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edge 0 is the first rising edge after the origin is set (t = -1).
    task automatic goEdge(input int k);
        waitEdges(k - t);
        t = k;
    endtask

    task automatic tapKey(input bit isUp);
        if (isUp) key_up_n = 1'b0; else key_dn_n = 1'b0;
        t = -1;
        goEdge(9);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        goEdge(25);
    endtask

    initial begin
        rst_n    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        waitEdges(3);
        rst_n = 1'b1;
        waitEdges(2);
        chk("reset_angle", angle_out, 8'h00);
        chk("reset_step", angle_step, 1'b0);
        chk("reset_repeat", repeat_active, 1'b0);

        // Single press: step lands exactly at edge 7.
        key_up_n = 1'b0;
        t = -1;
        goEdge(6);
        chk("press_e6_angle", angle_out, 8'h00);
        chk("press_e6_step", angle_step, 1'b0);
        goEdge(7);
        chk("press_e7_angle", angle_out, 8'h01);
        chk("press_e7_step", angle_step, 1'b1);
        goEdge(8);
        chk("press_e8_step", angle_step, 1'b0);
        goEdge(9);
        key_up_n = 1'b1;
        goEdge(25);
        chk("press_final_angle", angle_out, 8'h01);
        chk("press_step_count", stepCnt, 1);
        chk("press_repeat", repeat_active, 1'b0);

        // Bounces of 3 cycles must be rejected.
        repeat (4) begin
            key_dn_n = 1'b0;
            waitEdges(3);
            key_dn_n = 1'b1;
            waitEdges(3);
        end
        waitEdges(10);
        chk("bounce_angle", angle_out, 8'h01);
        chk("bounce_step_count", stepCnt, 1);

        // Wrap in both directions.
        tapKey(1'b0);
        chk("down_to_00", angle_out, 8'h00);
        tapKey(1'b0);
        chk("wrap_00_to_ff", angle_out, 8'hFF);
        tapKey(1'b1);
        chk("wrap_ff_to_00", angle_out, 8'h00);
        chk("wrap_step_count", stepCnt, 4);

        // Hold up; raw release after edge 53, debounced release at edge 60.
        baseCnt  = stepCnt;
        key_up_n = 1'b0;
        t = -1;
        goEdge(7);
        chk("hold_e7_angle", angle_out, 8'h01);
        goEdge(26);
        chk("hold_e26_angle", angle_out, 8'h01);
        chk("hold_e26_repeat", repeat_active, 1'b0);
        goEdge(27);
`ifdef TRIG_ANGLE_REPEAT_EN
        chk("hold_e27_angle", angle_out, 8'h02);
        chk("hold_e27_step", angle_step, 1'b1);
        chk("hold_e27_repeat", repeat_active, 1'b1);
        goEdge(32);
        chk("hold_e32_angle", angle_out, 8'h03);
        goEdge(52);
        chk("hold_e52_angle", angle_out, 8'h07);
        goEdge(53);
        key_up_n = 1'b1;
        goEdge(57);
        chk("hold_e57_angle", angle_out, 8'h08);
        chk("hold_e57_step", angle_step, 1'b1);
        goEdge(60);
        chk("hold_e60_repeat", repeat_active, 1'b1);
        goEdge(61);
        chk("hold_e61_repeat", repeat_active, 1'b0);
        goEdge(70);
        chk("hold_final_angle", angle_out, 8'h08);
        chk("hold_step_count", stepCnt - baseCnt, 8);
        expAngle = 8'h08;
`else
        chk("hold_e27_angle", angle_out, 8'h01);
        chk("hold_e27_repeat", repeat_active, 1'b0);
        goEdge(53);
        key_up_n = 1'b1;
        goEdge(70);
        chk("hold_final_angle", angle_out, 8'h01);
        chk("hold_step_count", stepCnt - baseCnt, 1);
        chk("hold_repeat", repeat_active, 1'b0);
        expAngle = 8'h01;
`endif

        // Lock: down pressed 10 cycles into an up hold blocks all steps.
        baseCnt  = stepCnt;
        key_up_n = 1'b0;
        t = -1;
        goEdge(7);
        chk("lock_e7_angle", angle_out, expAngle + 8'd1);
        goEdge(9);
        key_dn_n = 1'b0;
        goEdge(40);
        chk("lock_e40_angle", angle_out, expAngle + 8'd1);
        chk("lock_e40_repeat", repeat_active, 1'b0);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        goEdge(60);
        chk("lock_step_count", stepCnt - baseCnt, 1);
        tapKey(1'b0);
        chk("after_lock_down", angle_out, expAngle);

        // Reset while the up key is held (in REPEAT when enabled).
        key_up_n = 1'b0;
        t = -1;
        goEdge(30);
`ifdef TRIG_ANGLE_REPEAT_EN
        chk("prerst_repeat", repeat_active, 1'b1);
        chk("prerst_angle", angle_out, expAngle + 8'd2);
`else
        chk("prerst_angle", angle_out, expAngle + 8'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_async_angle", angle_out, 8'h00);
        chk("rst_async_step", angle_step, 1'b0);
        chk("rst_async_repeat", repeat_active, 1'b0);
        waitEdges(2);
        rst_n = 1'b1;
        baseCnt = stepCnt;
        t = -1;
        goEdge(6);
        chk("rst_e6_angle", angle_out, 8'h00);
        goEdge(7);
        chk("rst_e7_angle", angle_out, 8'h01);
        chk("rst_e7_step", angle_step, 1'b1);
        key_up_n = 1'b1;
        goEdge(25);
        chk("rst_step_count", stepCnt - baseCnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trig_angle_entry.md
# trig_angle_entry

Upstream angle-entry stage for the sine/cosine datapath. Converts two raw, bouncing, active-low DE10-Lite push-buttons (KEY up / KEY down) into a clean 8-bit phase angle. The angle is 0x00–0xFF, mapping 0..2π in steps of 2π/256. The output drives the `cosIn`/`sineIn` angle inputs of the trig lookup blocks directly. Provides synchronisation, per-key debounce, single-step on press, optional hold-to-auto-repeat, and modulo-256 wrap.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key change (10 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25000000, cycles from the press step to the first auto-repeat step (0.5 s).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps (0.1 s).
- RESET_ANGLE, 8'h00, value `angle_out` takes on reset.

Ports:
- clk  in  1  system clock (50 MHz); single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_up_n  in  1  raw up button, active low, asynchronous to clk.
- key_dn_n  in  1  raw down button, active low, asynchronous to clk.
- angle_out  out  8  current angle; registered.
- angle_step  out  1  one-cycle pulse in the same cycle `angle_out` takes a new value.
- repeat_active  out  1  high while a held key is producing auto-repeat steps.

## Operation
- Each key passes through a 2-FF synchroniser. The synchronisers reset to 1 (released).
- Debounce is per key. A counter runs while the synchronised level differs from the debounced level.
  - It clears whenever the two levels match.
  - The debounced level flips on the cycle the counter reaches DEBOUNCE_CYCLES.
  - Debounced levels reset to released.
- A press event is a debounced released→pressed transition. A release is the reverse transition.
- FSM states: IDLE, HOLD, REPEAT, LOCK. Reset state is IDLE.
  - IDLE, up press only: angle_out += 1; go to HOLD with dir = up.
  - IDLE, down press only: angle_out −= 1; go to HOLD with dir = down.
  - IDLE, both keys debounced-pressed in the same cycle: no step; go to LOCK.
  - HOLD: the timer counts from the press step.
    - If the held key is still pressed after REPEAT_DELAY cycles, step once in dir and go to REPEAT.
    - Release of the held key → IDLE, no step.
  - REPEAT: step in dir every REPEAT_PERIOD cycles. Release → IDLE.
  - HOLD/REPEAT, the other key becomes debounced-pressed: no step on that cycle; go to LOCK.
  - LOCK: no steps. Return to IDLE only when both keys are debounced-released.
- Arithmetic is unsigned 8-bit, modulo 256: 0xFF + 1 = 0x00 and 0x00 − 1 = 0xFF. No saturation and no flag.
- repeat_active = 1 only in state REPEAT.
- angle_step = 1 exactly in the cycles `angle_out` changes. It is never asserted without a change.

## Timing
- Reset values: angle_out = RESET_ANGLE, angle_step = 0, repeat_active = 0. Timers and debounce counters are 0.
- Reset is asynchronous. Assertion mid-hold or mid-repeat aborts immediately.
  - After release of rst_n, a key still held low must complete a full debounce.
  - That press is then treated as a fresh press: one step, then HOLD.
- Press latency: a raw key falls and stays low from edge 0. angle_out changes and angle_step pulses at edge DEBOUNCE_CYCLES + 3.
  - 2 cycles synchroniser, DEBOUNCE_CYCLES debounce, 1 cycle FSM/register.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no step and no state change.
- First repeat step: exactly REPEAT_DELAY cycles after the press step. Later repeat steps are spaced exactly REPEAT_PERIOD cycles apart.
- Release: no step occurs on or after the cycle the debounced release is seen.
  - A repeat step scheduled for that same cycle is suppressed.

## Configuration
- TRIG_ANGLE_REPEAT_EN defined: the full FSM, including REPEAT and repeat_active, as above.
- TRIG_ANGLE_REPEAT_EN undefined: the REPEAT state and its timer are not compiled.
  - HOLD waits only for release (or a lock condition); a held key yields exactly one step.
  - repeat_active is tied to 0.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
All scenarios use bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, with the macro defined unless stated.
- Reset, then key_up_n low at edge 0 and held 10 cycles, then released → angle_out 0x00→0x01 at edge 7; single angle_step pulse; back in IDLE.
- key_dn_n pulses low for 3 cycles, repeated 4 times with 3-cycle gaps → angle_out stays 0x00; no angle_step.
- From 0x00, press down once → 0xFF. From 0xFF, press up once → 0x00.
- Hold up for 60 cycles → steps at edges 7, 27, 32, 37, 42, 47, 52, 57 (0x01..0x08). repeat_active is high from edge 27 until the release is debounced.
- Hold up, then press down 10 cycles later → no further steps; LOCK until both released. A subsequent single down press steps −1.
- Macro undefined: hold up for 60 cycles → exactly one step; repeat_active stays 0.
- rst_n pulsed low mid-REPEAT with up still held → angle_out = 0x00 immediately. After rst_n deasserts, the next step is at edge 7 counted from rst_n release.
